vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 56 +++++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: standard timing sets, colour-bar table and line/frame total helper.
package vga_pkg;

   localparam int VGA_H_ACTIVE  = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_ACTIVE  = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;

   // {r,g,b} channel enables, left-to-right bar order
   localparam logic [2:0] BAR_WHITE   = 3'b111;
   localparam logic [2:0] BAR_YELLOW  = 3'b110;
   localparam logic [2:0] BAR_CYAN    = 3'b011;
   localparam logic [2:0] BAR_GREEN   = 3'b010;
   localparam logic [2:0] BAR_MAGENTA = 3'b101;
   localparam logic [2:0] BAR_RED     = 3'b100;
   localparam logic [2:0] BAR_BLUE    = 3'b001;
   localparam logic [2:0] BAR_BLACK   = 3'b000;

   function automatic int vga_total(
      input int act,
      input int fp,
      input int sync,
      input int bp
   );
      return act + fp + sync + bp;
   endfunction

   function automatic logic [2:0] bar_colour(input logic [2:0] idx);
      logic [2:0] c;
      unique case (idx)
         3'd0: c = BAR_WHITE;
         3'd1: c = BAR_YELLOW;
         3'd2: c = BAR_CYAN;
         3'd3: c = BAR_GREEN;
         3'd4: c = BAR_MAGENTA;
         3'd5: c = BAR_RED;
         3'd6: c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, DEPTH-stage shift register; DEPTH=0 is a wire.
module vga_delay_line #(
   parameter int           W     = 1,
   parameter int           DEPTH = 1,
   parameter logic [W-1:0] INIT  = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q_o = d_i;
      end else begin : g_shift
         logic [W-1:0] stage_q [DEPTH];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < DEPTH; i++)
                  stage_q[i] <= INIT;
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++)
                  stage_q[i] <= stage_q[i-1];
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/DE generator with pixel-latency alignment.
// Define VGA_TEST_PATTERN_EN to replace pix_data with eight vertical colour bars.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int PIX_LAT  = 1,
   parameter int RGB_W    = 24,
   parameter int FCNT_W   = 16
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic              blank,
   input  logic [RGB_W-1:0]  pix_data,
   output logic              pix_req,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [RGB_W-1:0]  rgb,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
`ifdef VGA_TEST_PATTERN_EN
   localparam int DW      = 6;
`else
   localparam int DW      = 3;
`endif

   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [VW-1:0]     v_cnt_q, v_cnt_d;
   logic              h_wrap, hs_raw, vs_raw;
   logic              blank_l_q, blank_l_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              de_q, de_d;
   logic [RGB_W-1:0]  rgb_q, rgb_d, colour;
   logic              fs_q, fs_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [DW-1:0]     dl_in, dl_out;
   logic              hs_dly, vs_dly, de_pre;

   always_comb begin
      h_wrap  = (int'(h_cnt_q) == H_TOTAL - 1);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap)
         v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
   end

   always_comb begin
      pix_req = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
      pos_x   = pix_req ? 10'(h_cnt_q) : '0;
      pos_y   = pix_req ? 10'(v_cnt_q) : '0;
      hs_raw  = (int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
      vs_raw  = (int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int CW = RGB_W / 3;
   logic [2:0] bar_idx, bar_rgb;
   assign bar_idx = 3'((int'(h_cnt_q) * 8) / H_ACTIVE);
   assign dl_in   = {bar_idx, hs_raw, vs_raw, pix_req};
   assign bar_rgb = bar_colour(dl_out[5:3]);
   assign colour  = RGB_W'({{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}});
`else
   assign dl_in   = {hs_raw, vs_raw, pix_req};
   assign colour  = pix_data;
`endif

   vga_delay_line #(
      .W     (DW),
      .DEPTH (PIX_LAT),
      .INIT  ('0)
   ) u_dly (
      .clk_i  (vga_clk),
      .rst_ni (sys_rst_n),
      .d_i    (dl_in),
      .q_o    (dl_out)
   );

   assign {hs_dly, vs_dly, de_pre} = dl_out[2:0];

   // blank only changes across a line boundary so a line is never torn
   always_comb begin
      blank_l_d = h_wrap ? blank : blank_l_q;
      hsync_d   = hs_dly ^ ~H_POL;
      vsync_d   = vs_dly ^ ~V_POL;
      de_d      = de_pre;
      rgb_d     = (de_pre && !blank_l_q) ? colour : '0;
      fs_d      = (h_cnt_q == '0) && (v_cnt_q == '0);
      fcnt_d    = fcnt_q + FCNT_W'(fs_q);
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         blank_l_q <= 1'b1;
         hsync_q   <= ~H_POL;
         vsync_q   <= ~V_POL;
         de_q      <= 1'b0;
         rgb_q     <= '0;
         fs_q      <= 1'b0;
         fcnt_q    <= '0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         blank_l_q <= blank_l_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         rgb_q     <= rgb_d;
         fs_q      <= fs_d;
         fcnt_q    <= fcnt_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_q;

endmodule
